// File: rtl/add_round_keys_if.sv
// Bus bundle for the AddRoundKey stage: state/tag and key in, registered result out.
interface add_round_keys_if;
  logic         enable;
  logic [131:0] data_in;   // [131:128] round tag, [127:0] AES state
  logic [127:0] key_in;    // round key, byte 0 in [127:120]
  logic [131:0] data_out;  // [131:128] tag, [127:0] state ^ key

  // Upstream side: drives state, key and enable, observes the result.
  modport master (
    output enable,
    output data_in,
    output key_in,
    input  data_out
  );

  // Stage side: consumes state, key and enable, drives the registered result.
  modport slave (
    input  enable,
    input  data_in,
    input  key_in,
    output data_out
  );
endinterface

// File: rtl/add_round_keys.sv
// AES AddRoundKey stage: 128-bit state XOR round key, 4-bit round tag carried
// through untouched, one register of latency with hold on enable=0.
module add_round_keys (
  input  logic             clk,
  input  logic             n_rst,
  add_round_keys_if.slave  bus
);

  localparam int unsigned StateWidth = 128;
  localparam int unsigned TagWidth   = 4;
  localparam int unsigned NumBytes   = StateWidth / 8;
  localparam int unsigned OutWidth   = StateWidth + TagWidth;

  logic [StateWidth-1:0] state_xor;
  logic [OutWidth-1:0]   result;
  logic [OutWidth-1:0]   out_reg;

  // Byte-lane XOR of state and key; lanes are independent, no carries.
  always_comb begin
    state_xor = '0;
    for (int b = 0; b < NumBytes; b++) begin
      state_xor[b*8 +: 8] = bus.data_in[b*8 +: 8] ^ bus.key_in[b*8 +: 8];
    end
  end

  // Assemble next output: tag passes straight through, never keyed.
  always_comb begin
    result = {bus.data_in[OutWidth-1:StateWidth], state_xor};
  end

  // Output register: async clear, capture only on enabled edges.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      out_reg <= '0;
    end else if (bus.enable) begin
      out_reg <= result;
    end
  end

  assign bus.data_out = out_reg;

endmodule

// File: tb/tb_add_round_keys.sv
// Directed bench for add_round_keys: vector table plus reset/hold/enable sequences.
module tb_add_round_keys;

  logic clk;
  logic n_rst;
  int   tests_run;
  int   tests_failed;

  add_round_keys_if bus ();

  add_round_keys dut (
    .clk   (clk),
    .n_rst (n_rst),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [131:0] data;
    logic [127:0] key;
    logic [131:0] exp;
  } vec_t;

  vec_t vecs [7];

  task automatic check(input string name, input logic [131:0] act, input logic [131:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Drive inputs just after a rising edge so they are stable at the next one.
  task automatic drive(input logic en, input logic [131:0] d, input logic [127:0] k);
    bus.enable  = en;
    bus.data_in = d;
    bus.key_in  = k;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;

    vecs[0] = '{{4'h7, 128'h00112233445566778899AABBCCDDEEFF},
                128'hFFEEDDCCBBAA99887766554433221100,
                {4'h7, 128'hFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFF}};
    vecs[1] = '{{4'hA, 128'h0},
                128'h0123456789ABCDEFFEDCBA9876543210,
                {4'hA, 128'h0123456789ABCDEFFEDCBA9876543210}};
    vecs[2] = '{{4'h3, 128'h2B7E151628AED2A6ABF7158809CF4F3C},
                128'h2B7E151628AED2A6ABF7158809CF4F3C,
                {4'h3, 128'h0}};
    vecs[3] = '{{4'hF, 128'hFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFF},
                128'hFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFF,
                {4'hF, 128'h0}};
    vecs[4] = '{{4'h5, 128'h0123456789ABCDEFFEDCBA9876543210},
                128'h0,
                {4'h5, 128'h0123456789ABCDEFFEDCBA9876543210}};
    vecs[5] = '{{4'h0, 8'hFF, 112'h0, 8'h00},
                {8'h00, 112'h0, 8'h01},
                {4'h0, 8'hFF, 112'h0, 8'h01}};
    vecs[6] = '{{4'h9, 128'hF0F0F0F0F0F0F0F0F0F0F0F0F0F0F0F0},
                128'h0F0F0F0F0F0F0F0F0F0F0F0F0F0F0F0F,
                {4'h9, 128'hFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFF}};

    // Reset with non-zero inputs and enable high: output held at zero.
    n_rst = 1'b0;
    drive(1'b1, {4'hC, 128'h1234}, 128'h5678);
    #2;
    check("reset_immediate", bus.data_out, 132'h0);
    for (int i = 0; i < 3; i++) begin
      step();
      check("reset_clocked", bus.data_out, 132'h0);
    end

    // Release reset between edges with enable already high: the edge before
    // release must not have captured; the next edge captures.
    drive(1'b1, vecs[0].data, vecs[0].key);
    n_rst = 1'b1;
    #1;
    check("release_no_capture", bus.data_out, 132'h0);
    step();
    check("standard_vector", bus.data_out, vecs[0].exp);

    // Hold: enable low, inputs change, output must not move.
    drive(1'b0, {4'h1, 128'hDEADBEEF}, 128'hCAFEF00D);
    for (int i = 0; i < 3; i++) begin
      step();
      check("hold", bus.data_out, vecs[0].exp);
    end

    // Vector table, one capture per edge.
    for (int i = 0; i < 7; i++) begin
      drive(1'b1, vecs[i].data, vecs[i].key);
      step();
      check($sformatf("vec%0d", i), bus.data_out, vecs[i].exp);
    end

    // Enable toggling every cycle: odd edges hold, even edges capture.
    drive(1'b0, vecs[1].data, vecs[1].key);
    step();
    check("toggle_hold", bus.data_out, vecs[6].exp);
    drive(1'b1, vecs[1].data, vecs[1].key);
    step();
    check("toggle_capture", bus.data_out, vecs[1].exp);

    // Async reset mid-run: clear without a clock edge, then resume.
    drive(1'b1, vecs[2].data, vecs[2].key);
    #2;
    n_rst = 1'b0;
    #1;
    check("async_clear", bus.data_out, 132'h0);
    n_rst = 1'b1;
    #1;
    check("async_clear_held", bus.data_out, 132'h0);
    step();
    check("resume_capture", bus.data_out, vecs[2].exp);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
